// File: rtl/blu.sv
// Branch logic unit: resolves the branch condition against the accumulator
// combinationally and keeps registered flags plus saturating branch statistics.
module blu #(
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 Reset_n,
   input  logic [ACC_WIDTH-1:0] Acc,
   input  logic                 BranchCycle,
   input  logic [1:0]           BranchCond,
   input  logic                 CntClear,
   output logic                 DoBranch,
   output logic                 DoBranchQ,
   output logic                 FlagN,
   output logic                 FlagZ,
   output logic                 FlagP,
   output logic [CNT_WIDTH-1:0] EvalCount,
   output logic [CNT_WIDTH-1:0] TakenCount
);

   localparam logic [1:0] CondNeg     = 2'b00;
   localparam logic [1:0] CondZero    = 2'b01;
   localparam logic [1:0] CondNonZero = 2'b10;
   localparam logic [1:0] CondPos     = 2'b11;

   localparam logic [CNT_WIDTH-1:0] CntMax = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   logic accNeg;
   logic accZero;
   logic accPos;
   logic condTrue;

   // Exactly one of the three flags is set for any accumulator value.
   assign accNeg  = Acc[ACC_WIDTH-1];
   assign accZero = (Acc == '0);
   assign accPos  = !accNeg && !accZero;

   always_comb begin
      condTrue = 1'b0;
      case (BranchCond)
         CondNeg:     condTrue = accNeg;
         CondZero:    condTrue = accZero;
         CondNonZero: condTrue = !accZero;
         CondPos:     condTrue = accPos;
         default:     condTrue = 1'b0;
      endcase
   end

   // Feeds the PC-select mux in the same cycle, so it must stay purely combinational.
   assign DoBranch = BranchCycle && condTrue;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         DoBranchQ <= 1'b0;
         FlagN     <= 1'b0;
         FlagZ     <= 1'b0;
         FlagP     <= 1'b0;
      end else begin
         DoBranchQ <= DoBranch;
         FlagN     <= accNeg;
         FlagZ     <= accZero;
         FlagP     <= accPos;
      end
   end

   // Taken only advances when an evaluation does, so TakenCount never passes EvalCount.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         EvalCount  <= '0;
         TakenCount <= '0;
      end else if (CntClear) begin
         EvalCount  <= '0;
         TakenCount <= '0;
      end else begin
         if (BranchCycle && (EvalCount != CntMax)) begin
            EvalCount <= EvalCount + CntOne;
         end
         if (DoBranch && (TakenCount != CntMax)) begin
            TakenCount <= TakenCount + CntOne;
         end
      end
   end

endmodule

// File: tb/tb_blu.sv
// Directed bench for blu: reference model predicts outputs into an expected
// queue at drive time; outputs are popped and compared after they settle.
module tb_blu;

   localparam int AccW = 16;
   localparam int CntW = 4;
   localparam int CntMaxI = (1 << CntW) - 1;

   logic            clk;
   logic            rstN;
   logic [AccW-1:0] acc;
   logic            bc;
   logic [1:0]      cond;
   logic            cntClear;
   logic            doBranch;
   logic            doBranchQ;
   logic            flagN;
   logic            flagZ;
   logic            flagP;
   logic [CntW-1:0] evalCount;
   logic [CntW-1:0] takenCount;

   logic [31:0] expQ[$];
   int vectors = 0;
   int miscompares = 0;

   int  mEval = 0;
   int  mTaken = 0;
   bit  mDoQ = 0;
   bit  mN = 0;
   bit  mZ = 0;
   bit  mP = 0;

   blu #(.ACC_WIDTH(AccW), .CNT_WIDTH(CntW)) dut (
      .CLK        (clk),
      .Reset_n    (rstN),
      .Acc        (acc),
      .BranchCycle(bc),
      .BranchCond (cond),
      .CntClear   (cntClear),
      .DoBranch   (doBranch),
      .DoBranchQ  (doBranchQ),
      .FlagN      (flagN),
      .FlagZ      (flagZ),
      .FlagP      (flagP),
      .EvalCount  (evalCount),
      .TakenCount (takenCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit refTaken(input logic [AccW-1:0] a, input logic [1:0] c, input logic b);
      int s;
      bit r;
      s = int'($signed(a));
      case (c)
         2'd0:    r = (s < 0);
         2'd1:    r = (s == 0);
         2'd2:    r = (s != 0);
         default: r = (s > 0);
      endcase
      return b && r;
   endfunction

   task automatic pushExp(input logic [31:0] v);
      expQ.push_back(v);
   endtask

   task automatic checkPop(input string tag, input logic [31:0] observed);
      logic [31:0] expected;
      vectors++;
      if (expQ.size() == 0) begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=<empty queue>", tag, observed);
      end else begin
         expected = expQ.pop_front();
         assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         end
      end
   endtask

   task automatic pushRegs();
      pushExp(32'(mDoQ));
      pushExp(32'(mN));
      pushExp(32'(mZ));
      pushExp(32'(mP));
      pushExp(32'(mEval));
      pushExp(32'(mTaken));
      pushExp(32'd1);
   endtask

   task automatic popRegs();
      checkPop("DoBranchQ", 32'(doBranchQ));
      checkPop("FlagN", 32'(flagN));
      checkPop("FlagZ", 32'(flagZ));
      checkPop("FlagP", 32'(flagP));
      checkPop("EvalCount", 32'(evalCount));
      checkPop("TakenCount", 32'(takenCount));
      checkPop("TakenLeEval", 32'(takenCount <= evalCount));
   endtask

   // Predict the next edge from current inputs, clock once, compare all registers.
   task automatic tick();
      bit d;
      int s;
      d = refTaken(acc, cond, bc);
      s = int'($signed(acc));
      if (cntClear) begin
         mEval  = 0;
         mTaken = 0;
      end else begin
         if (bc && mEval != CntMaxI) mEval++;
         if (d && mTaken != CntMaxI) mTaken++;
      end
      mDoQ = d;
      mN = (s < 0);
      mZ = (s == 0);
      mP = (s > 0);
      pushRegs();
      @(posedge clk);
      #1;
      popRegs();
   endtask

   task automatic checkComb(input string tag);
      pushExp(32'(refTaken(acc, cond, bc)));
      #1;
      checkPop(tag, 32'(doBranch));
   endtask

   logic [AccW-1:0] accTable[5];

   initial begin
      accTable[0] = 16'hFFFD;
      accTable[1] = 16'h0000;
      accTable[2] = 16'd12;
      accTable[3] = 16'h8000;
      accTable[4] = 16'h7FFF;

      // Reset state
      rstN = 1'b0;
      acc = '0;
      bc = 1'b0;
      cond = 2'd0;
      cntClear = 1'b0;
      #12;
      pushRegs();
      popRegs();
      rstN = 1'b1;
      tick();

      // Combinational decision for each boundary accumulator, all codes, BranchCycle 0/1
      for (int a = 0; a < 5; a++) begin
         acc = accTable[a];
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) begin
               bc = b[0];
               cond = c[1:0];
               checkComb("DoBranch");
            end
         end
         tick();
      end

      // Eight evaluations at Acc=12 cycling codes: 8 evaluated, 4 taken
      cntClear = 1'b1;
      tick();
      cntClear = 1'b0;
      acc = 16'd12;
      bc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cond = 2'(i % 4);
         tick();
      end
      pushExp(32'd8);
      checkPop("EvalAfter8", 32'(evalCount));
      pushExp(32'd4);
      checkPop("TakenAfter8", 32'(takenCount));

      // Run past saturation with random accumulator and codes
      for (int i = 0; i < 20; i++) begin
         acc = AccW'($urandom_range(0, 65535));
         cond = 2'($urandom_range(0, 3));
         bc = 1'b1;
         tick();
      end
      pushExp(32'(CntMaxI));
      checkPop("EvalSaturated", 32'(evalCount));

      // Clear wins over a simultaneous branch evaluation
      cntClear = 1'b1;
      acc = 16'd12;
      cond = 2'd3;
      bc = 1'b1;
      tick();
      cntClear = 1'b0;

      // Build nonzero counts, then reset asynchronously between edges
      acc = 16'hFFFD;
      cond = 2'd0;
      for (int i = 0; i < 3; i++) tick();
      #3;
      rstN = 1'b0;
      mEval = 0;
      mTaken = 0;
      mDoQ = 0;
      mN = 0;
      mZ = 0;
      mP = 0;
      #1;
      pushRegs();
      popRegs();
      acc = 16'h0000;
      cond = 2'd1;
      bc = 1'b1;
      checkComb("DoBranchInReset");
      bc = 1'b0;
      checkComb("DoBranchInResetIdle");
      #1;
      rstN = 1'b1;
      acc = 16'd5;
      cond = 2'd3;
      bc = 1'b1;
      tick();
      pushExp(32'd1);
      checkPop("EvalAfterRelease", 32'(evalCount));

      if (expQ.size() != 0) begin
         miscompares++;
         $error("FAIL ExpQueueDrain observed=%0d expected=0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/blu.md
# blu

Branch logic unit of the miniscule-ISA processor datapath. It evaluates the accumulator against the branch condition encoded in a branch instruction and raises `DoBranch` in the same cycle, so the PC-select mux can load the branch target. It also keeps registered copies of the decision and the accumulator flags, plus saturating statistics counters for debug and performance visibility.

## Interface
- `ACC_WIDTH`, 16, accumulator width in bits; two's-complement signed.
- `CNT_WIDTH`, 16, width of each statistics counter.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Acc`  in  ACC_WIDTH  current accumulator value, signed.
- `BranchCycle`  in  1  high during the cycle in which a branch instruction is resolved.
- `BranchCond`  in  2  condition code: 00 negative, 01 zero, 10 nonzero, 11 positive.
- `CntClear`  in  1  synchronous clear of both counters.
- `DoBranch`  out  1  combinational branch-taken decision.
- `DoBranchQ`  out  1  `DoBranch` registered.
- `FlagN`, `FlagZ`, `FlagP`  out  1 each  registered accumulator sign flags.
- `EvalCount`  out  CNT_WIDTH  number of clock edges with `BranchCycle` high.
- `TakenCount`  out  CNT_WIDTH  number of clock edges with `DoBranch` high.

## Operation
- Flags are derived combinationally from `Acc`:
  - `n` = MSB of `Acc`.
  - `z` = (`Acc` == 0).
  - `p` = !`n` && !`z`.
- Condition result by `BranchCond`:
  - 00 → `n` (Acc < 0).
  - 01 → `z` (Acc == 0).
  - 10 → !`z` (Acc != 0).
  - 11 → `p` (Acc > 0).
- `DoBranch` = `BranchCycle` && condition result. It is 0 whenever `BranchCycle` is 0, regardless of `Acc` or `BranchCond`.
- `DoBranch` is purely combinational: it has no dependence on `CLK` or on `Reset_n`.
- Registered path, on each rising `CLK`:
  - `DoBranchQ` ← `DoBranch`.
  - `FlagN` / `FlagZ` / `FlagP` ← `n` / `z` / `p`.
- Counters, on each rising `CLK`:
  - If `CntClear` is high, both counters ← 0. Clear has priority over any increment in the same cycle.
  - Otherwise `EvalCount` increments by 1 when `BranchCycle` = 1, and `TakenCount` increments by 1 when `DoBranch` = 1.
  - Both counters saturate at all-ones; they never wrap to 0.
- Invariant: `TakenCount` ≤ `EvalCount` at all times.
- Boundary values of `Acc`:
  - Most-negative value (0x8000) counts as negative.
  - 0x7FFF counts as positive.
  - 0x0000 counts as zero only.
  - Exactly one of `n`, `z`, `p` is high at any time.

## Timing
- `DoBranch`: zero-cycle latency, combinational from `Acc`, `BranchCycle` and `BranchCond`.
- `DoBranchQ` and the flags: valid one cycle after their inputs are sampled.
- Counters reflect an event on the edge following it.
- Reset: asserting `Reset_n` low immediately forces `DoBranchQ`, `FlagN`, `FlagZ`, `FlagP`, `EvalCount` and `TakenCount` to 0.
  - Exception: `FlagZ` resets to 0 as well, not 1.
  - Reset mid-operation discards all counts. The first edge after release resumes normal updates.
- No handshake; inputs are sampled every cycle.

## Test plan
- `Acc`=-3 (0xFFFD), `BranchCycle`=1, `BranchCond` 00/01/10/11 → `DoBranch` 1/0/1/0. With `BranchCycle`=0 → 0 for all four codes.
- `Acc`=0, `BranchCycle`=1, codes 00/01/10/11 → `DoBranch` 0/1/0/0. With `BranchCycle`=0 → 0 for all codes.
- `Acc`=12, `BranchCycle`=1, codes 00/01/10/11 → `DoBranch` 0/0/1/1. Also check 0x8000 → 1/0/1/0 and 0x7FFF → 0/0/1/1.
- Hold `BranchCycle`=1 with `Acc`=12 and cycle through codes 00/01/10/11 for 8 clocks → `EvalCount`=8, `TakenCount`=4. `DoBranchQ` follows `DoBranch` one cycle later.
- Preload `EvalCount` near saturation by running 2^CNT_WIDTH+5 branch cycles (or shrink `CNT_WIDTH` to 4) → count holds at all-ones. Then assert `CntClear` together with `BranchCycle`=1 → both counters read 0 on the next cycle.
- Drop `Reset_n` asynchronously between clock edges with nonzero counters → all registered outputs 0 immediately. `DoBranch` still tracks its inputs during reset.
